rr_arb: RTL and testbench
=========================

Name: rr_arb

Overview:
- Parametrised round-robin arbiter with registered outputs. It is the stateful successor to the fixed-priority Arb/RArb.
- Accepts N request lines and issues a one-hot grant plus its binary index one cycle later.
- Priority rotates after every grant, so no requester starves. An optional lock holds a grant across multi-cycle transactions.
- Sits in front of shared resources (bus, memory port, Mux3-style datapath select) wherever multiple masters contend.

Parameters:
- N, 8, number of requesters (N >= 2)
- W, 3, width of encoded grant index; must satisfy 2^W >= N

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- r  input  N  request vector; bit i = requester i wants access
- lock  input  1  when high, current grant is held while its requester keeps r asserted
- g  output  N  registered one-hot grant (all-zero when idle)
- gb  output  W  registered binary index of granted requester
- valid  output  1  registered; high when g is non-zero

Behaviour:
- Reset (reset low, asynchronous): g=0, gb=0, valid=0, priority pointer ptr=0. Release is synchronous to clk. The first arbitration occurs on the first rising edge with reset high.
- State: ptr (W bits, range 0..N-1) marks the highest-priority requester. Output registers g, gb and valid are also state.
- Latency: requests sampled at edge k appear as a grant after edge k. Exactly one cycle of latency; there is no combinational path from r to g.
- Arbitration each edge, with no hold in effect:
  - Search r starting at index ptr, ascending, wrapping from N-1 to 0.
  - The first set bit i wins: g <= (1<<i), gb <= i, valid <= 1, ptr <= (i+1) mod N.
- Wrap-around: i=N-1 sets ptr to 0. The search for ptr=p covers p..N-1 then 0..p-1.
- Idle: r=0 gives g <= 0, gb <= 0, valid <= 0, and ptr is unchanged.
- Hold rule: when valid=1, lock=1 and r[gb]=1 are all sampled at the edge:
  - g, gb and valid keep their values.
  - ptr is unchanged; it already points past the holder.
  - Other requests are ignored.
- Lock with the holder's request dropped (lock=1, r[gb]=0): normal arbitration from ptr that same edge. There is no idle bubble.
- lock=1 while valid=0 has no effect; normal arbitration applies.
- Fairness: with lock=0 and all requests high, grants cycle 0,1,...,N-1,0. A requester continuously asserting r waits at most N-1 grants.
- Request change in the same cycle as a grant: the grant reflects the sampled r only. A requester that drops r after being granted still holds g for that one cycle. The consumer qualifies g with its own r if required.
- Invariant: g is zero or one-hot, always. g[gb]==1 whenever valid=1. valid == |g.
- Reset mid-operation: all outputs clear immediately, asynchronously. ptr returns to 0 and any lock is discarded.
- Non-power-of-two N: ptr and gb never take values >= N. Encoded widths compare against N-1 for wrap.

Test Plan:
- Reset check: hold reset low with r=8'hFF, lock=1 -> g=0, gb=0, valid=0 throughout. Release reset -> next edge g=8'h01, gb=0, valid=1.
- Rotation: N=8, lock=0, r=8'hFF constant for 9 cycles -> gb sequence 0,1,2,3,4,5,6,7,0 with g one-hot matching each cycle.
- Skip and wrap: ptr=6 after grant to 5, then r=8'b0000_0101 -> grant gb=0 (search 6,7,0), ptr=1. Next edge, same r -> gb=2.
- Lock hold: r=8'h0A, lock=1, first grant gb=1 -> gb stays 1 for 4 cycles while r[1]=1. Drop r[1] with r=8'h08 -> next edge gb=3 with no idle cycle.
- Idle/single: r=0 for 3 cycles -> valid=0, g=0, ptr unchanged. Then r=8'h80 -> g=8'h80, gb=7, valid=1, ptr wraps to 0.
- Async reset mid-lock: lock=1 holding gb=4, assert reset between edges -> g, gb and valid clear within the same cycle. After release with r=8'h10 -> gb=4 granted via search from ptr=0.

Source files
------------

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant and index are registered, so there is one cycle from request to grant.
// No backpressure; lock holds the current grant while its holder keeps requesting.
module rr_arb #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] r,
   input  logic         lock,
   output logic [N-1:0] g,
   output logic [W-1:0] gb,
   output logic         valid
);

   logic [W-1:0] ptr;
   logic [W-1:0] win;
   logic [W-1:0] ptr_nxt;
   logic [N-1:0] g_nxt;
   logic         found;
   logic         hold;

   // Scan from ptr upward, wrapping at N-1; the first requester seen wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      g_nxt = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && r[j]) begin
            found    = 1'b1;
            win      = W'(j);
            g_nxt[j] = 1'b1;
         end
      end
   end

   assign hold    = valid & lock & r[gb];
   assign ptr_nxt = (win == W'(N - 1)) ? '0 : win + W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         g     <= '0;
         gb    <= '0;
         valid <= 1'b0;
         ptr   <= '0;
      end else if (!hold) begin
         g     <= g_nxt;
         gb    <= win;
         valid <= found;
         // An idle cycle leaves the priority pointer where it was.
         if (found) ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb: directed vector table, async-reset corner, then random traffic against a queue-free reference model.
module tb_rr_arb;
   localparam int N = 8;
   localparam int W = 3;

   logic         clk;
   logic         reset;
   logic [N-1:0] r;
   logic         lock;
   logic [N-1:0] g;
   logic [W-1:0] gb;
   logic         valid;

   int checks = 0;
   int errors = 0;

   // Reference model state: plain integers.
   int m_ptr;
   int m_gb;
   int m_valid;

   rr_arb #(.N(N), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .r     (r),
      .lock  (lock),
      .g     (g),
      .gb    (gb),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] vr;
      logic         vlock;
      int           egb;
      int           evalid;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int onehot(input int idx, input int v);
      return v ? (1 << idx) : 0;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_gb    = 0;
      m_valid = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] rr, input logic lk);
      int i;
      if (m_valid == 1 && lk && rr[m_gb]) return;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (rr[i]) begin
            m_gb    = i;
            m_valid = 1;
            m_ptr   = (i + 1) % N;
            return;
         end
      end
      m_gb    = 0;
      m_valid = 0;
   endtask

   // Apply inputs, take one edge, sample 1 time unit later.
   task automatic step(input logic [N-1:0] rr, input logic lk);
      r    = rr;
      lock = lk;
      @(posedge clk);
      model_edge(rr, lk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".g"}, int'(g), onehot(m_gb, m_valid));
      chk({tag, ".gb"}, int'(gb), m_gb);
      chk({tag, ".valid"}, int'(valid), m_valid);
   endtask

   initial begin
      reset = 1'b0;
      r     = '1;
      lock  = 1'b1;
      model_reset();

      // Rotation, skip/wrap, lock hold, lock drop, idle, single top requester.
      for (int k = 0; k < 9; k++) vecs.push_back('{8'hFF, 1'b0, k % N, 1});
      vecs.push_back('{8'h20, 1'b0, 5, 1});
      vecs.push_back('{8'h05, 1'b0, 0, 1});
      vecs.push_back('{8'h05, 1'b0, 2, 1});
      vecs.push_back('{8'h01, 1'b0, 0, 1});
      for (int k = 0; k < 4; k++) vecs.push_back('{8'h0A, 1'b1, 1, 1});
      vecs.push_back('{8'h08, 1'b1, 3, 1});
      for (int k = 0; k < 3; k++) vecs.push_back('{8'h00, 1'b0, 0, 0});
      vecs.push_back('{8'h80, 1'b0, 7, 1});
      vecs.push_back('{8'hFF, 1'b0, 0, 1});
      vecs.push_back('{8'h10, 1'b1, 4, 1});
      vecs.push_back('{8'hFF, 1'b1, 4, 1});

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("rst.g", int'(g), 0);
         chk("rst.gb", int'(gb), 0);
         chk("rst.valid", int'(valid), 0);
      end
      reset = 1'b1;

      foreach (vecs[k]) begin
         step(vecs[k].vr, vecs[k].vlock);
         chk($sformatf("vec%0d.gb", k), int'(gb), vecs[k].egb);
         chk($sformatf("vec%0d.valid", k), int'(valid), vecs[k].evalid);
         chk($sformatf("vec%0d.g", k), int'(g), onehot(vecs[k].egb, vecs[k].evalid));
      end

      // Asynchronous reset between edges while a lock is being held on 4.
      #2;
      reset = 1'b0;
      #1;
      chk("arst.g", int'(g), 0);
      chk("arst.gb", int'(gb), 0);
      chk("arst.valid", int'(valid), 0);
      model_reset();
      reset = 1'b1;
      step(8'h10, 1'b1);
      chk("arst_rel.gb", int'(gb), 4);
      chk("arst_rel.valid", int'(valid), 1);
      step(8'h03, 1'b0);
      chk("arst_ptr.gb", int'(gb), 0);

      // Random traffic with occasional mid-cycle resets.
      for (int it = 0; it < 600; it++) begin
         logic [N-1:0] rr;
         case ($urandom_range(0, 3))
            0: rr = N'($urandom);
            1: rr = N'($urandom & $urandom & $urandom);
            2: rr = N'(1 << $urandom_range(0, N - 1));
            default: rr = '1;
         endcase
         step(rr, 1'($urandom_range(0, 2) != 0));
         chk_model($sformatf("rnd%0d", it));
         if ($urandom_range(0, 79) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_reset();
            chk_model($sformatf("rndrst%0d", it));
            reset = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
